dmem_port_arbiter: RTL
======================

# dmem_port_arbiter

Two-requester arbiter and sequencer for the single-port 32-word data memory. It sits between the core load/store path and a DMA/debug port. It grants one access per cycle and drives the memory address, write data and read/write select. It registers read data back to the winning requester and flags out-of-range or misaligned accesses. The core has fixed priority, and a starvation counter guarantees DMA forward progress.

## Interface
Parameters:
- DEPTH, 32: memory depth in 32-bit words; legal word index 0..DEPTH-1
- STARVE_MAX, 4: consecutive DMA-blocked cycles after which DMA wins (≥1)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- core_req  in  1  core access request, held until core_gnt
- core_we  in  1  1 = write, 0 = read
- core_addr  in  32  byte address
- core_wdata  in  32  write data
- core_gnt  out  1  combinational grant, same cycle as accepted request
- core_rvalid  out  1  one-cycle response pulse
- core_rdata  out  32  read data, valid with core_rvalid
- core_err  out  1  error flag, valid with core_rvalid
- dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_rvalid, dma_rdata, dma_err: same as core_*
- mem_addr  out  32  byte address to memory (word index = mem_addr[31:2])
- mem_wdata  out  32  write data to memory
- mem_rw  out  1  1 = write, committed at posedge clk; 0 = read
- mem_rdata  in  32  combinational memory read data

## Operation
- Winner selection, combinational, each cycle:
  - force_dma = dma_req && (starve_cnt == STARVE_MAX).
  - If force_dma, DMA wins.
  - Else if core_req, core wins.
  - Else if dma_req, DMA wins.
  - Else idle.
- Only the winner's gnt is high. gnt means the access is consumed this cycle.
- Winner drives mem_addr and mem_wdata from its inputs. mem_rw = winner_we && !bad.
- Idle cycle: mem_addr=0, mem_wdata=0, mem_rw=0.
- bad = (addr[1:0] != 0) || (addr[31:2] ≥ DEPTH).
  - A bad access is granted but suppressed: mem_rw=0, no write.
  - Its response carries err=1, rdata=0.
- Response registers, updated at each posedge clk:
  - rvalid is high for the previous cycle's winner only.
  - Read: rdata = mem_rdata sampled at that edge.
  - Write: rdata = 0, rvalid=1 (write acknowledge).
  - err = bad of that access.
  - The non-winner has rvalid=0. Its rdata and err hold their last value.
- starve_cnt, width clog2(STARVE_MAX+1), updated at posedge clk:
  - Resets to 0 when dma_gnt is high or dma_req is low.
  - Increments when dma_req is high and dma_gnt is low.
  - Saturates at STARVE_MAX.
- Simultaneous core_req and dma_req with starve_cnt < STARVE_MAX: core wins and the counter increments.

## Timing
- Grant latency: 0 cycles (gnt is combinational on req).
- Write: committed at the posedge ending the grant cycle. Acknowledge (rvalid) is high in the following cycle.
- Read: data is captured at the posedge ending the grant cycle and presented with rvalid in the following cycle. Total latency is 1 cycle.
- Back-to-back accesses from the same or different requesters are allowed every cycle. Throughput is 1 access per cycle.
- With STARVE_MAX=N and the core requesting continuously, DMA waits at most N cycles. It is granted in the (N+1)th cycle of its request.
- Reset (rst_n low, asynchronous):
  - All rvalid, err and rdata outputs go to 0 immediately.
  - starve_cnt goes to 0.
  - mem_rw is forced to 0 while rst_n is low.
  - Responses in flight are dropped, with no rvalid after release.
- After rst_n deasserts, the first posedge can capture a new grant.

## Test plan
- Core write 0xDEADBEEF to 0x08, then core read 0x08 → core_gnt both cycles. Write ack rvalid=1, err=0. Read rvalid next cycle with rdata=0xDEADBEEF.
- core_req and dma_req held continuously (STARVE_MAX=4), distinct addresses → core granted 4 cycles, DMA granted in cycle 5, then core again. starve_cnt returns to 0 after the DMA grant.
- DMA write 0x12345678 to 0x7C (word 31), then read 0x80 → first ok. Second: dma_rvalid=1, dma_err=1, dma_rdata=0, mem_rw never 1 for that access.
- Core write to 0x06 (misaligned) → core_gnt=1, mem_rw=0, core_err=1 next cycle, memory word 1 unchanged on readback.
- rst_n pulsed low for half a cycle right after a core read grant → core_rvalid stays 0 and all outputs are 0 during reset. The next core read of 0x08 returns the previously written value.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: the core load/store path and a DMA/debug port share a
// single-port 32-bit data memory. One access is granted per cycle. The core
// has fixed priority, and a starvation counter guarantees DMA forward progress.
// Read data and error status come back one cycle later on registered outputs.
module dmem_port_arbiter #(
  parameter int DEPTH      = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic        core_gnt,
  output logic        core_rvalid,
  output logic [31:0] core_rdata,
  output logic        core_err,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic        dma_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rw,
  input  logic [31:0] mem_rdata
);

  localparam int                CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_MAX);
  localparam logic [31:0]       DEPTH_W = 32'(DEPTH);

  // Misaligned or beyond the last word: granted but never touches memory.
  function automatic logic addr_bad(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= DEPTH_W);
  endfunction

  logic [CNT_W-1:0] starve_cnt;
  logic             force_dma;
  logic             sel_core;
  logic             sel_dma;
  logic             win_we;
  logic             win_bad;
  logic [31:0]      win_addr;
  logic [31:0]      win_wdata;
  logic [31:0]      rsp_rdata_p0;

  // Stage p0: pick the winner and drive the memory port from its request.
  always_comb begin
    force_dma = dma_req && (starve_cnt == CNT_MAX);
    sel_dma   = force_dma || (dma_req && !core_req);
    sel_core  = core_req && !force_dma;
    win_we    = 1'b0;
    win_addr  = 32'h0;
    win_wdata = 32'h0;
    if (sel_core) begin
      win_we    = core_we;
      win_addr  = core_addr;
      win_wdata = core_wdata;
    end else if (sel_dma) begin
      win_we    = dma_we;
      win_addr  = dma_addr;
      win_wdata = dma_wdata;
    end
    win_bad      = (sel_core || sel_dma) && addr_bad(win_addr);
    rsp_rdata_p0 = (win_we || win_bad) ? 32'h0 : mem_rdata;
    core_gnt     = sel_core;
    dma_gnt      = sel_dma;
    mem_addr     = win_addr;
    mem_wdata    = win_wdata;
    // Writes must never reach memory while reset is held.
    mem_rw       = win_we && !win_bad && rst_n;
  end

  // Count consecutive cycles DMA waits; saturates so DMA is forced through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!dma_req || sel_dma) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CNT_MAX) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // Stage p1: register the response for last cycle's winner; loser holds data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_rvalid <= 1'b0;
      core_rdata  <= 32'h0;
      core_err    <= 1'b0;
      dma_rvalid  <= 1'b0;
      dma_rdata   <= 32'h0;
      dma_err     <= 1'b0;
    end else begin
      core_rvalid <= sel_core;
      dma_rvalid  <= sel_dma;
      if (sel_core) begin
        core_rdata <= rsp_rdata_p0;
        core_err   <= win_bad;
      end
      if (sel_dma) begin
        dma_rdata <= rsp_rdata_p0;
        dma_err   <= win_bad;
      end
    end
  end

endmodule
